// File: rtl/data_mem_bridge.sv
// Data-side memory stage: local word RAM plus an MMIO store buffer drained over valid/ready.
// Optional feature macro WBUF_STATUS_EN: MMIO loads at offset 0 return {wb_overflow, 0..., wb_count}.
module data_mem_bridge #(
    parameter int         DEPTH_LOG2     = 2,
    parameter int         RAM_WORDS_LOG2 = 6,
    parameter logic [3:0] MMIO_NIB       = 4'hF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  MemWrite,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  per_valid,
    output logic [31:0]           per_addr,
    output logic [31:0]           per_data,
    input  logic                  per_ready,
    output logic [DEPTH_LOG2:0]   wb_count,
    output logic                  wb_overflow
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  RAM_WORDS = 1 << RAM_WORDS_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [31:0] ram_mem [RAM_WORDS];
    logic [31:0] fifo_addr_mem [DEPTH];
    logic [31:0] fifo_data_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic                      mmio;
    logic [RAM_WORDS_LOG2-1:0] ram_idx;
    logic                      push_req;
    logic                      push_accept;
    logic                      pop;

    assign mmio        = (ALUResult[31:28] == MMIO_NIB);
    assign ram_idx     = ALUResult[RAM_WORDS_LOG2+1:2];
    assign push_req    = MemWrite & mmio;
    assign pop         = (count_q != '0) & per_ready;
    // A full buffer still takes a store when the head leaves in the same cycle.
    assign push_accept = push_req & ((count_q < DEPTH_CNT) | pop);

    // RAM keeps its contents across Reset.
    always_ff @(posedge CLK) begin
        if (MemWrite && !mmio) begin
            ram_mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_accept) begin
            fifo_addr_mem[wr_ptr_q] <= ALUResult;
            fifo_data_mem[wr_ptr_q] <= WriteData;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_req && !push_accept) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign per_valid   = (count_q != '0);
    assign per_addr    = per_valid ? fifo_addr_mem[rd_ptr_q] : 32'h0;
    assign per_data    = per_valid ? fifo_data_mem[rd_ptr_q] : 32'h0;
    assign wb_count    = count_q;
    assign wb_overflow = ovf_q;

    // A same-cycle store to the addressed word is not visible until after the edge.
    always_comb begin
        ReadData = 32'h0;
        if (!mmio) begin
            ReadData = ram_mem[ram_idx];
        end
`ifdef WBUF_STATUS_EN
        else if (ALUResult[3:2] == 2'b00) begin
            ReadData               = 32'h0;
            ReadData[31]           = ovf_q;
            ReadData[DEPTH_LOG2:0] = count_q;
        end
`else
        else begin
            ReadData = 32'h0;
        end
`endif
    end

endmodule
